// File: rtl/register_file_scoreboard_if.sv
// rtl/register_file_scoreboard_if.sv - write/read/reserve bus for the register file scoreboard
interface register_file_scoreboard_if #(
  parameter int WIDTH     = 16,
  parameter int NUM_REGS  = 16,
  parameter int ADDR_BITS = 4
);
  logic                      wr_en;
  logic [ADDR_BITS-1:0]      wr_addr;
  logic [WIDTH-1:0]          wr_data;
  logic [ADDR_BITS-1:0]      rd_addr_a;
  logic [WIDTH-1:0]          rd_data_a;
  logic                      rd_busy_a;
  logic [ADDR_BITS-1:0]      rd_addr_b;
  logic [WIDTH-1:0]          rd_data_b;
  logic                      rd_busy_b;
  logic                      rsv_en;
  logic [ADDR_BITS-1:0]      rsv_addr;
  logic                      rsv_ok;
  logic [ADDR_BITS:0]        busy_count;
  logic [WIDTH*NUM_REGS-1:0] data_out;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, rsv_en, rsv_addr,
    input  rd_data_a, rd_busy_a, rd_data_b, rd_busy_b, rsv_ok, busy_count, data_out
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, rsv_en, rsv_addr,
    output rd_data_a, rd_busy_a, rd_data_b, rd_busy_b, rsv_ok, busy_count, data_out
  );
endinterface

// File: rtl/register_file_scoreboard.sv
// rtl/register_file_scoreboard.sv - register file with write-through bypass and busy scoreboard
module register_file_scoreboard #(
  parameter int WIDTH     = 16,
  parameter int NUM_REGS  = 16,
  parameter int ADDR_BITS = 4,
  parameter int ZERO_REG  = 1
) (
  input logic clk,
  input logic reset,
  register_file_scoreboard_if.slave bus
);
  localparam logic [ADDR_BITS:0] NUM_REGS_W = (ADDR_BITS+1)'(NUM_REGS);

  logic [WIDTH-1:0]          regs [NUM_REGS];
  logic [NUM_REGS-1:0]       busy;
  logic [NUM_REGS-1:0]       busy_next;
  logic [ADDR_BITS:0]        busy_count;
  logic [ADDR_BITS:0]        count_next;
  logic [WIDTH-1:0]          stored_a, stored_b;
  logic                      busy_a, busy_b, rsv_busy;
  logic                      wr_legal, rsv_ok, rsv_set;
  logic                      wr_hit_a, wr_hit_b, rsv_hit_a, rsv_hit_b;
  logic [WIDTH*NUM_REGS-1:0] flat;

  function automatic logic in_range(input logic [ADDR_BITS-1:0] a);
    return {1'b0, a} < NUM_REGS_W;
  endfunction

  function automatic logic is_zero(input logic [ADDR_BITS-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // A write is legal only to an in-range, non-hardwired register; it also releases that register.
  assign wr_legal = bus.wr_en && in_range(bus.wr_addr) && !is_zero(bus.wr_addr);

  // Look up stored data and busy bits for both read ports and the reservation address.
  always_comb begin
    stored_a = '0;
    stored_b = '0;
    busy_a   = 1'b0;
    busy_b   = 1'b0;
    rsv_busy = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.rd_addr_a == ADDR_BITS'(i)) begin
        stored_a = regs[i];
        busy_a   = busy[i];
      end
      if (bus.rd_addr_b == ADDR_BITS'(i)) begin
        stored_b = regs[i];
        busy_b   = busy[i];
      end
      if (bus.rsv_addr == ADDR_BITS'(i)) rsv_busy = busy[i];
    end
  end

  // A busy register can be re-reserved only when this cycle's write releases it.
  assign rsv_ok  = bus.rsv_en && in_range(bus.rsv_addr) &&
                   (!rsv_busy || (wr_legal && (bus.wr_addr == bus.rsv_addr)));
  // The hardwired zero register accepts reservations but never becomes busy.
  assign rsv_set = rsv_ok && !is_zero(bus.rsv_addr);

  assign wr_hit_a  = wr_legal && (bus.wr_addr == bus.rd_addr_a);
  assign wr_hit_b  = wr_legal && (bus.wr_addr == bus.rd_addr_b);
  assign rsv_hit_a = rsv_set && (bus.rsv_addr == bus.rd_addr_a);
  assign rsv_hit_b = rsv_set && (bus.rsv_addr == bus.rd_addr_b);

  assign bus.rd_data_a = wr_hit_a ? bus.wr_data : stored_a;
  assign bus.rd_data_b = wr_hit_b ? bus.wr_data : stored_b;
  // Same-cycle release clears the reported busy unless a new reservation replaces it.
  assign bus.rd_busy_a = busy_a && (!wr_hit_a || rsv_hit_a);
  assign bus.rd_busy_b = busy_b && (!wr_hit_b || rsv_hit_b);
  assign bus.rsv_ok    = rsv_ok;

  // Next busy vector: release by write first, then set by accepted reservation, then popcount.
  always_comb begin
    busy_next  = busy;
    count_next = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_legal && (bus.wr_addr == ADDR_BITS'(i))) busy_next[i] = 1'b0;
      if (rsv_set && (bus.rsv_addr == ADDR_BITS'(i))) busy_next[i] = 1'b1;
      count_next = count_next + (ADDR_BITS+1)'(busy_next[i]);
    end
  end

  // Busy bits and their count move together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_next;
      busy_count <= count_next;
    end
  end

  // Register storage with a single write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_legal && (bus.wr_addr == ADDR_BITS'(i))) regs[i] <= bus.wr_data;
      end
    end
  end

  // Flatten stored contents for the debug view; no bypass here.
  always_comb begin
    flat = '0;
    for (int i = 0; i < NUM_REGS; i++) flat[i*WIDTH +: WIDTH] = regs[i];
  end

  assign bus.data_out   = flat;
  assign bus.busy_count = busy_count;
endmodule

// File: tb/tb_register_file_scoreboard.sv
// tb/tb_register_file_scoreboard.sv - directed bench for register_file_scoreboard
module tb_register_file_scoreboard;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  register_file_scoreboard_if #(.WIDTH(8), .NUM_REGS(4), .ADDR_BITS(2)) bus0 ();
  register_file_scoreboard_if #(.WIDTH(8), .NUM_REGS(6), .ADDR_BITS(3)) bus1 ();

  register_file_scoreboard #(.WIDTH(8), .NUM_REGS(4), .ADDR_BITS(2), .ZERO_REG(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  register_file_scoreboard #(.WIDTH(8), .NUM_REGS(6), .ADDR_BITS(3), .ZERO_REG(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus0.wr_en = 0; bus0.wr_addr = 0; bus0.wr_data = 0; bus0.rsv_en = 0; bus0.rsv_addr = 0;
    bus1.wr_en = 0; bus1.wr_addr = 0; bus1.wr_data = 0; bus1.rsv_en = 0; bus1.rsv_addr = 0;
  endtask

  task automatic test_reset();
    idle_all();
    bus0.rd_addr_a = 0; bus0.rd_addr_b = 0; bus1.rd_addr_a = 0; bus1.rd_addr_b = 0;
    reset = 1'b1;
    tick();
    tick();
    checks++; if (bus0.data_out !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp %h", bus0.data_out, 32'h0); end
    checks++; if (bus0.busy_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus0.busy_count); end
    checks++; if (bus1.data_out !== 48'h0) begin errors++; $display("FAIL reset_data1 got %h exp 0", bus1.data_out); end
    reset = 1'b0;
    #1;
  endtask

  task automatic test_write();
    bus0.wr_en = 1; bus0.wr_addr = 2; bus0.wr_data = 8'hA5; bus0.rd_addr_a = 2;
    #1;
    checks++; if (bus0.data_out !== 32'h0) begin errors++; $display("FAIL write_pre_edge got %h exp 0", bus0.data_out); end
    tick();
    bus0.wr_en = 0;
    #1;
    checks++; if (bus0.data_out !== 32'h00A50000) begin errors++; $display("FAIL write_data_out got %h exp 00a50000", bus0.data_out); end
    checks++; if (bus0.rd_data_a !== 8'hA5) begin errors++; $display("FAIL write_read_a got %h exp a5", bus0.rd_data_a); end
  endtask

  task automatic test_bypass();
    bus0.wr_en = 1; bus0.wr_addr = 3; bus0.wr_data = 8'h3C; bus0.rd_addr_b = 3; bus0.rd_addr_a = 2;
    #1;
    checks++; if (bus0.rd_data_b !== 8'h3C) begin errors++; $display("FAIL bypass_b got %h exp 3c", bus0.rd_data_b); end
    checks++; if (bus0.rd_data_a !== 8'hA5) begin errors++; $display("FAIL bypass_a_other got %h exp a5", bus0.rd_data_a); end
    checks++; if (bus0.data_out[31:24] !== 8'h00) begin errors++; $display("FAIL bypass_no_dbg got %h exp 00", bus0.data_out[31:24]); end
    tick();
    bus0.wr_en = 0; bus0.rd_addr_a = 3;
    #1;
    checks++; if (bus0.data_out[31:24] !== 8'h3C) begin errors++; $display("FAIL bypass_stored got %h exp 3c", bus0.data_out[31:24]); end
    checks++; if (bus0.rd_data_a !== 8'h3C) begin errors++; $display("FAIL both_ports_a got %h exp 3c", bus0.rd_data_a); end
    checks++; if (bus0.rd_data_b !== 8'h3C) begin errors++; $display("FAIL both_ports_b got %h exp 3c", bus0.rd_data_b); end
  endtask

  task automatic test_scoreboard();
    bus0.rsv_en = 1; bus0.rsv_addr = 1; bus0.rd_addr_a = 1;
    #1;
    checks++; if (bus0.rsv_ok !== 1'b1) begin errors++; $display("FAIL rsv_first got %b exp 1", bus0.rsv_ok); end
    checks++; if (bus0.rd_busy_a !== 1'b0) begin errors++; $display("FAIL rsv_busy_lat got %b exp 0", bus0.rd_busy_a); end
    tick();
    bus0.rsv_en = 0;
    #1;
    checks++; if (bus0.rd_busy_a !== 1'b1) begin errors++; $display("FAIL rsv_busy got %b exp 1", bus0.rd_busy_a); end
    checks++; if (bus0.busy_count !== 3'd1) begin errors++; $display("FAIL rsv_count got %0d exp 1", bus0.busy_count); end
    bus0.rsv_en = 1;
    #1;
    checks++; if (bus0.rsv_ok !== 1'b0) begin errors++; $display("FAIL rsv_second got %b exp 0", bus0.rsv_ok); end
    tick();
    checks++; if (bus0.busy_count !== 3'd1) begin errors++; $display("FAIL rsv_drop_count got %0d exp 1", bus0.busy_count); end
    bus0.wr_en = 1; bus0.wr_addr = 1; bus0.wr_data = 8'h11;
    #1;
    checks++; if (bus0.rsv_ok !== 1'b1) begin errors++; $display("FAIL wr_rsv_ok got %b exp 1", bus0.rsv_ok); end
    checks++; if (bus0.rd_busy_a !== 1'b1) begin errors++; $display("FAIL wr_rsv_busy got %b exp 1", bus0.rd_busy_a); end
    checks++; if (bus0.rd_data_a !== 8'h11) begin errors++; $display("FAIL wr_rsv_bypass got %h exp 11", bus0.rd_data_a); end
    tick();
    bus0.wr_en = 0; bus0.rsv_en = 0;
    #1;
    checks++; if (bus0.rd_busy_a !== 1'b1) begin errors++; $display("FAIL wr_rsv_stays got %b exp 1", bus0.rd_busy_a); end
    checks++; if (bus0.busy_count !== 3'd1) begin errors++; $display("FAIL wr_rsv_count got %0d exp 1", bus0.busy_count); end
    checks++; if (bus0.data_out[15:8] !== 8'h11) begin errors++; $display("FAIL wr_rsv_data got %h exp 11", bus0.data_out[15:8]); end
  endtask

  task automatic test_release();
    bus0.wr_en = 1; bus0.wr_addr = 1; bus0.wr_data = 8'h22; bus0.rd_addr_a = 1; bus0.rd_addr_b = 1;
    #1;
    checks++; if (bus0.rd_busy_a !== 1'b0) begin errors++; $display("FAIL release_busy_a got %b exp 0", bus0.rd_busy_a); end
    checks++; if (bus0.rd_busy_b !== 1'b0) begin errors++; $display("FAIL release_busy_b got %b exp 0", bus0.rd_busy_b); end
    checks++; if (bus0.busy_count !== 3'd1) begin errors++; $display("FAIL release_count_lat got %0d exp 1", bus0.busy_count); end
    tick();
    bus0.wr_en = 0;
    #1;
    checks++; if (bus0.busy_count !== 3'd0) begin errors++; $display("FAIL release_count got %0d exp 0", bus0.busy_count); end
    checks++; if (bus0.data_out[15:8] !== 8'h22) begin errors++; $display("FAIL release_data got %h exp 22", bus0.data_out[15:8]); end
    for (int i = 0; i < 4; i++) begin
      bus0.rsv_en = 1; bus0.rsv_addr = 2'(i);
      #1;
      checks++; if (bus0.rsv_ok !== 1'b1) begin errors++; $display("FAIL rsv_all_%0d got %b exp 1", i, bus0.rsv_ok); end
      tick();
    end
    bus0.rsv_en = 0;
    #1;
    checks++; if (bus0.busy_count !== 3'd4) begin errors++; $display("FAIL rsv_all_count got %0d exp 4", bus0.busy_count); end
    bus0.rsv_en = 1; bus0.rsv_addr = 0;
    #1;
    checks++; if (bus0.rsv_ok !== 1'b0) begin errors++; $display("FAIL rsv_full got %b exp 0", bus0.rsv_ok); end
    tick();
    bus0.rsv_en = 0;
    #1;
    checks++; if (bus0.busy_count !== 3'd4) begin errors++; $display("FAIL rsv_nowrap got %0d exp 4", bus0.busy_count); end
  endtask

  task automatic test_async_reset();
    bus0.wr_en = 1; bus0.wr_addr = 1; bus0.wr_data = 8'h11;
    tick();
    bus0.wr_en = 0; bus0.rsv_en = 1; bus0.rsv_addr = 1;
    tick();
    bus0.rsv_en = 0; bus0.rd_addr_a = 1;
    #1;
    checks++; if (bus0.rd_busy_a !== 1'b1) begin errors++; $display("FAIL pre_reset_busy got %b exp 1", bus0.rd_busy_a); end
    checks++; if (bus0.data_out[15:8] !== 8'h11) begin errors++; $display("FAIL pre_reset_data got %h exp 11", bus0.data_out[15:8]); end
    bus0.wr_en = 1; bus0.wr_addr = 2; bus0.wr_data = 8'h77;
    #1;
    reset = 1'b1;
    #1;
    checks++; if (bus0.data_out !== 32'h0) begin errors++; $display("FAIL async_data got %h exp 0", bus0.data_out); end
    checks++; if (bus0.busy_count !== 3'd0) begin errors++; $display("FAIL async_count got %0d exp 0", bus0.busy_count); end
    checks++; if (bus0.rd_busy_a !== 1'b0) begin errors++; $display("FAIL async_busy got %b exp 0", bus0.rd_busy_a); end
    tick();
    bus0.wr_en = 0;
    reset = 1'b0;
    #1;
    checks++; if (bus0.data_out !== 32'h0) begin errors++; $display("FAIL async_write_lost got %h exp 0", bus0.data_out); end
    tick();
    checks++; if (bus0.busy_count !== 3'd0) begin errors++; $display("FAIL async_count_after got %0d exp 0", bus0.busy_count); end
  endtask

  task automatic test_zero_reg();
    bus1.wr_en = 1; bus1.wr_addr = 0; bus1.wr_data = 8'hFF; bus1.rd_addr_a = 0;
    #1;
    checks++; if (bus1.rd_data_a !== 8'h00) begin errors++; $display("FAIL zero_bypass got %h exp 00", bus1.rd_data_a); end
    tick();
    bus1.wr_en = 0;
    #1;
    checks++; if (bus1.rd_data_a !== 8'h00) begin errors++; $display("FAIL zero_read got %h exp 00", bus1.rd_data_a); end
    checks++; if (bus1.data_out !== 48'h0) begin errors++; $display("FAIL zero_dbg got %h exp 0", bus1.data_out); end
    bus1.rsv_en = 1; bus1.rsv_addr = 0;
    #1;
    checks++; if (bus1.rsv_ok !== 1'b1) begin errors++; $display("FAIL zero_rsv_ok got %b exp 1", bus1.rsv_ok); end
    tick();
    bus1.rsv_en = 0;
    #1;
    checks++; if (bus1.busy_count !== 4'd0) begin errors++; $display("FAIL zero_rsv_count got %0d exp 0", bus1.busy_count); end
    checks++; if (bus1.rd_busy_a !== 1'b0) begin errors++; $display("FAIL zero_rsv_busy got %b exp 0", bus1.rd_busy_a); end
    bus1.wr_en = 1; bus1.wr_addr = 7; bus1.wr_data = 8'h55; bus1.rd_addr_b = 7;
    #1;
    checks++; if (bus1.rd_data_b !== 8'h00) begin errors++; $display("FAIL oor_bypass got %h exp 00", bus1.rd_data_b); end
    tick();
    bus1.wr_en = 0;
    #1;
    checks++; if (bus1.data_out !== 48'h0) begin errors++; $display("FAIL oor_write got %h exp 0", bus1.data_out); end
    checks++; if (bus1.rd_data_b !== 8'h00) begin errors++; $display("FAIL oor_read got %h exp 00", bus1.rd_data_b); end
    checks++; if (bus1.rd_busy_b !== 1'b0) begin errors++; $display("FAIL oor_busy got %b exp 0", bus1.rd_busy_b); end
    bus1.rsv_en = 1; bus1.rsv_addr = 7;
    #1;
    checks++; if (bus1.rsv_ok !== 1'b0) begin errors++; $display("FAIL oor_rsv got %b exp 0", bus1.rsv_ok); end
    tick();
    bus1.rsv_en = 0;
    #1;
    checks++; if (bus1.busy_count !== 4'd0) begin errors++; $display("FAIL oor_rsv_count got %0d exp 0", bus1.busy_count); end
    bus1.wr_en = 1; bus1.wr_addr = 5; bus1.wr_data = 8'h5A; bus1.rsv_en = 1; bus1.rsv_addr = 5; bus1.rd_addr_a = 5;
    #1;
    checks++; if (bus1.rsv_ok !== 1'b1) begin errors++; $display("FAIL top_rsv got %b exp 1", bus1.rsv_ok); end
    tick();
    bus1.wr_en = 0; bus1.rsv_en = 0;
    #1;
    checks++; if (bus1.data_out !== 48'h5A00_0000_0000) begin errors++; $display("FAIL top_data got %h exp 5a0000000000", bus1.data_out); end
    checks++; if (bus1.busy_count !== 4'd1) begin errors++; $display("FAIL top_count got %0d exp 1", bus1.busy_count); end
    checks++; if (bus1.rd_busy_a !== 1'b1) begin errors++; $display("FAIL top_busy got %b exp 1", bus1.rd_busy_a); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    test_reset();
    test_write();
    test_bypass();
    test_scoreboard();
    test_release();
    test_async_reset();
    test_zero_reg();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
